multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter USE_MEM_READY, default 1; when 0, mem_ready is ignored and treated as 1.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have clk, input, 1, rising-edge clock.
REQ-004 SHALL have reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have Op, input, 6, instruction opcode from instruction register.
REQ-006 SHALL have Funct, input, 6, R-type function field.
REQ-007 SHALL have Zero, input, 1, ALU zero flag.
REQ-008 SHALL have mem_ready, input, 1, memory access completes this cycle.
REQ-009 SHALL have these 1-bit outputs: IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, Illegal.
REQ-010 SHALL have ALUSrcB (2 bits): 00 reg, 01 const 4, 10 sign-imm, 11 imm<<2. SHALL have PCSrc (2 bits): 00 ALU, 01 ALUOut, 10 jump target. SHALL have ALUControl (3 bits).
REQ-011 SHALL have State, output, 4, current state encoding for debug.

Function
REQ-012 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. All outputs derive from State plus the listed inputs only.
REQ-013 SHALL perform FETCH as follows: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCWrite SHALL assert only in the cycle where mem_ready=1. The FSM stays in FETCH while mem_ready=0 and goes to DECODE when mem_ready=1.
REQ-014 SHALL perform DECODE as follows: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op: 100011/101011 go to MEMADR, 000000 to EXECUTE, 000100 to BRANCH, 001000 to ADDIEX, 000010 to JUMP, any other value to FETCH with Illegal=1 for that cycle.
REQ-015 SHALL perform MEMADR as follows: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state is MEMREAD for lw and MEMWRITE for sw.
REQ-016 SHALL perform MEMREAD with IorD=1. The FSM holds while mem_ready=0 and goes to MEMWB when mem_ready=1.
REQ-017 SHALL perform MEMWB with RegDst=0, MemtoReg=1, RegWrite=1, then go to FETCH.
REQ-018 SHALL perform MEMWRITE with IorD=1 and MemWrite=1, held continuously until mem_ready=1, then go to FETCH.
REQ-019 SHALL perform EXECUTE with ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to ALUWB.
REQ-020 SHALL perform ALUWB with RegDst=1, MemtoReg=0, RegWrite=1, then go to FETCH.
REQ-021 SHALL perform BRANCH with ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, then go to FETCH.
REQ-022 SHALL perform ADDIEX with ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDIWB.
REQ-023 SHALL perform ADDIWB with RegDst=0, MemtoReg=0, RegWrite=1, then go to FETCH.
REQ-024 SHALL perform JUMP with PCSrc=10 and PCWrite=1, then go to FETCH.
REQ-025 SHALL drive PCEn = PCWrite | (Branch & Zero), combinationally.
REQ-026 SHALL decode the ALU as follows: ALUOp 00 gives 010, ALUOp 01 gives 110. ALUOp 10 decodes Funct: 100000 gives 010, 100010 gives 110, 100100 gives 000, 100101 gives 001, 101010 gives 111, and any other Funct gives 010. No latch is inferred.
REQ-027 SHALL default every output not listed for a state to 0 (ALUSrcB and PCSrc to 00, ALUControl to 010).
REQ-028 SHALL have zero-wait latencies in cycles, FETCH through return to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-029 SHALL sample Op and Funct in DECODE and in later states; the datapath SHALL hold the IR stable between IRWrite pulses.

Reset
REQ-030 SHALL set State to FETCH on the clk edge where reset=1; this applies mid-instruction and includes aborting MEMWRITE.
REQ-031 SHALL force all outputs to 0 while reset=1 (ALUControl=010), including MemWrite, RegWrite, PCEn and IRWrite.

Structure
REQ-032 SHALL place state encodings, opcode constants (R, LW, SW, BEQ, ADDI, J), funct constants and ALUControl codes in shared package mips_pkg.
REQ-033 SHALL split into the FSM and one sub-module alu_decoder (ALUOp, Funct to ALUControl).

Verification
REQ-034 SHALL cover this scenario: reset high for 2 cycles mid-MEMWRITE, then low. Required response: State=0 and MemWrite=0 from the reset edge, and FETCH resumes.
REQ-035 SHALL cover this scenario: Op=100011, mem_ready tied 1. Required response: states 0,1,2,3,4,0 over 5 cycles, and RegWrite=1 with MemtoReg=1 only in state 4.
REQ-036 SHALL cover this scenario: Op=101011, mem_ready=0 for 3 cycles in MEMWRITE. Required response: MemWrite=1 for 4 consecutive cycles, then FETCH.
REQ-037 SHALL cover this scenario: Op=000100 with Zero=1, then Zero=0. Required response: PCEn=1 in BRANCH for Zero=1, PCEn=0 for Zero=0, and both take 3 cycles.
REQ-038 SHALL cover this scenario: Op=000000 with Funct=100010, 101010 and 111111. Required response: ALUControl in EXECUTE is 110, 111 and 010.
REQ-039 SHALL cover this scenario: Op=111111. Required response: Illegal=1 in DECODE, next state FETCH, and no RegWrite or MemWrite asserted.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct fields, ALU control codes and datapath mux selects.
package mips_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiEx   = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  localparam logic [2:0] AluCtlAnd = 3'b000;
  localparam logic [2:0] AluCtlOr  = 3'b001;
  localparam logic [2:0] AluCtlAdd = 3'b010;
  localparam logic [2:0] AluCtlSub = 3'b110;
  localparam logic [2:0] AluCtlSlt = 3'b111;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OpR) || (op == OpLw) || (op == OpSw) || (op == OpBeq) ||
           (op == OpAddi) || (op == OpJ);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALUOp and the R-type funct field to a 3-bit ALU control code.
module alu_decoder
  import mips_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = AluCtlAdd;
    case (alu_op_i)
      AluOpAdd: alu_control_o = AluCtlAdd;
      AluOpSub: alu_control_o = AluCtlSub;
      AluOpFunct: begin
        case (funct_i)
          FunctAdd: alu_control_o = AluCtlAdd;
          FunctSub: alu_control_o = AluCtlSub;
          FunctAnd: alu_control_o = AluCtlAnd;
          FunctOr:  alu_control_o = AluCtlOr;
          FunctSlt: alu_control_o = AluCtlSlt;
          default:  alu_control_o = AluCtlAdd;
        endcase
      end
      default: alu_control_o = AluCtlAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle MIPS datapath with memory wait-state support.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       PCEn,
  output logic       Illegal,
  output logic [3:0] State
);

  state_e  state_q, state_d;
  alu_op_e alu_op;
  logic    ready, pc_write, branch;

  assign ready = USE_MEM_READY ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: if (ready) state_d = StDecode;
      StDecode: begin
        case (Op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (Op == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  if (ready) state_d = StMemWb;
      StMemWrite: if (ready) state_d = StFetch;
      StExecute:  state_d = StAluWb;
      StAddiEx:   state_d = StAddiWb;
      default:    state_d = StFetch;
    endcase
  end

  // Outputs are decoded from the current state; reset overrides everything to idle.
  always_comb begin
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SrcBReg;
    PCSrc    = PcSrcAlu;
    alu_op   = AluOpAdd;
    pc_write = 1'b0;
    branch   = 1'b0;
    Illegal  = 1'b0;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          ALUSrcB  = SrcBFour;
          IRWrite  = ready;
          pc_write = ready;
        end
        StDecode: begin
          ALUSrcB = SrcBImmSh;
          Illegal = !is_legal_op(Op);
        end
        StMemAdr: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SrcBImm;
        end
        StMemRead: IorD = 1'b1;
        StMemWb: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        StMemWrite: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        StExecute: begin
          ALUSrcA = 1'b1;
          alu_op  = AluOpFunct;
        end
        StAluWb: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        StBranch: begin
          ALUSrcA = 1'b1;
          alu_op  = AluOpSub;
          PCSrc   = PcSrcAluOut;
          branch  = 1'b1;
        end
        StAddiEx: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SrcBImm;
        end
        StAddiWb: RegWrite = 1'b1;
        StJump: begin
          PCSrc    = PcSrcJump;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign PCEn  = pc_write | (branch & Zero);
  assign State = reset ? 4'd0 : state_q;

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct_i       (Funct),
    .alu_control_o (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected output vectors are
// computed by a reference model from the expected state sequence and compared at negedge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op, Funct;
  logic       Zero, mem_ready;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, Illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int n_tests = 0;
  int n_fail  = 0;
  logic [19:0] sb [$];

  // {State, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
  //  ALUSrcB, PCSrc, ALUControl, PCEn, Illegal}
  localparam logic [19:0] RstVec = {4'd0, 7'b0, 2'b00, 2'b00, 3'b010, 2'b00};

  multicycle_controller #(.USE_MEM_READY(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .ALUControl (ALUControl),
    .PCEn       (PCEn),
    .Illegal    (Illegal),
    .State      (State)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] snap();
    return {State, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
            ALUSrcB, PCSrc, ALUControl, PCEn, Illegal};
  endfunction

  function automatic logic [2:0] ref_alu(input logic [1:0] aop, input logic [5:0] fn);
    if (aop == 2'b01) return 3'b110;
    if (aop != 2'b10) return 3'b010;
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [19:0] model(input logic [3:0] st, input logic mr, input logic z,
                                        input logic [5:0] op, input logic [5:0] fn);
    logic iord, mw, irw, rd, m2r, rw, asa, pcw, br, ill;
    logic [1:0] asb, pcs, aop;
    {iord, mw, irw, rd, m2r, rw, asa, pcw, br, ill} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (st)
      4'd0:  begin asb = 2'b01; irw = mr; pcw = mr; end
      4'd1:  begin
        asb = 2'b11;
        ill = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
      end
      4'd2:  begin asa = 1'b1; asb = 2'b10; end
      4'd3:  iord = 1'b1;
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin iord = 1'b1; mw = 1'b1; end
      4'd6:  begin asa = 1'b1; aop = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; br = 1'b1; end
      4'd9:  begin asa = 1'b1; asb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin pcs = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    return {st, iord, mw, irw, rd, m2r, rw, asa, asb, pcs, ref_alu(aop, fn), pcw | (br & z), ill};
  endfunction

  task automatic test_reset();
    logic [19:0] got, want;
    reset = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      sb.push_back(RstVec);
      @(negedge clk);
      got = snap(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset cyc%0d got=%h want=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    logic [3:0] st [6];
    logic       mr [6];
    logic [19:0] got, want;
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    Op = 6'b100011; Funct = 6'd0; Zero = 1'b0;
    for (int c = 0; c < 6; c++) begin
      mem_ready = mr[c];
      sb.push_back(model(st[c], mr[c], Zero, Op, Funct));
      @(negedge clk);
      got = snap(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL lw cyc%0d got=%h want=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] st [8];
    logic       mr [8];
    logic [19:0] got, want;
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    Op = 6'b100011; Funct = 6'd0; Zero = 1'b0;
    for (int c = 0; c < 8; c++) begin
      mem_ready = mr[c];
      sb.push_back(model(st[c], mr[c], Zero, Op, Funct));
      @(negedge clk);
      got = snap(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL lw_wait cyc%0d got=%h want=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_wait();
    logic [3:0] st [9];
    logic       mr [9];
    logic [19:0] got, want;
    int mw_cnt;
    st = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    Op = 6'b101011; Funct = 6'd0; Zero = 1'b0; mw_cnt = 0;
    for (int c = 0; c < 9; c++) begin
      mem_ready = mr[c];
      sb.push_back(model(st[c], mr[c], Zero, Op, Funct));
      @(negedge clk);
      got = snap(); want = sb.pop_front(); n_tests++;
      if (MemWrite === 1'b1) mw_cnt++;
      if (got !== want) begin
        n_fail++; $display("FAIL sw_wait cyc%0d got=%h want=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (mw_cnt !== 4) begin
      n_fail++; $display("FAIL sw_memwrite_cycles got=%0d want=4", mw_cnt);
    end
  endtask

  task automatic test_reset_mid_memwrite();
    logic [3:0] st [4];
    logic [3:0] st2 [5];
    logic [19:0] got, want;
    st  = '{4'd0, 4'd1, 4'd2, 4'd5};
    st2 = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    Op = 6'b101011; Funct = 6'd0; Zero = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c < 3);
      sb.push_back(model(st[c], mem_ready, Zero, Op, Funct));
      @(negedge clk);
      got = snap(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL rst_mid pre cyc%0d got=%h want=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      sb.push_back(RstVec);
      @(negedge clk);
      got = snap(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL rst_mid hold cyc%0d got=%h want=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mem_ready = (c < 4);
      sb.push_back(model(st2[c], mem_ready, Zero, Op, Funct));
      @(negedge clk);
      got = snap(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL rst_mid resume cyc%0d got=%h want=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    logic [3:0] st [4];
    logic [19:0] got, want;
    st = '{4'd0, 4'd1, 4'd8, 4'd0};
    Op = 6'b000100; Funct = 6'd0;
    for (int k = 0; k < 2; k++) begin
      Zero = (k == 0);
      for (int c = 0; c < 4; c++) begin
        mem_ready = (c < 3);
        sb.push_back(model(st[c], mem_ready, Zero, Op, Funct));
        @(negedge clk);
        got = snap(); want = sb.pop_front(); n_tests++;
        if (got !== want) begin
          n_fail++; $display("FAIL beq z=%0b cyc%0d got=%h want=%h", Zero, c, got, want);
        end
        if (c == 2) begin
          n_tests++;
          if (PCEn !== Zero) begin
            n_fail++; $display("FAIL beq_pcen got=%b want=%b", PCEn, Zero);
          end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_rtype();
    logic [3:0] st [5];
    logic [5:0] fns [3];
    logic [2:0] acs [3];
    logic [19:0] got, want;
    st  = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    fns = '{6'b100010, 6'b101010, 6'b111111};
    acs = '{3'b110, 3'b111, 3'b010};
    Op = 6'b000000; Zero = 1'b0;
    for (int k = 0; k < 3; k++) begin
      Funct = fns[k];
      for (int c = 0; c < 5; c++) begin
        mem_ready = (c < 4);
        sb.push_back(model(st[c], mem_ready, Zero, Op, Funct));
        @(negedge clk);
        got = snap(); want = sb.pop_front(); n_tests++;
        if (got !== want) begin
          n_fail++; $display("FAIL rtype fn=%b cyc%0d got=%h want=%h", Funct, c, got, want);
        end
        if (c == 2) begin
          n_tests++;
          if (ALUControl !== acs[k]) begin
            n_fail++; $display("FAIL rtype_aluctl got=%b want=%b", ALUControl, acs[k]);
          end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_addi_jump();
    logic [3:0] sa [5];
    logic [3:0] sj [4];
    logic [19:0] got, want;
    sa = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
    sj = '{4'd0, 4'd1, 4'd11, 4'd0};
    Op = 6'b001000; Funct = 6'b100100; Zero = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mem_ready = (c < 4);
      sb.push_back(model(sa[c], mem_ready, Zero, Op, Funct));
      @(negedge clk);
      got = snap(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL addi cyc%0d got=%h want=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
    Op = 6'b000010;
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c < 3);
      sb.push_back(model(sj[c], mem_ready, Zero, Op, Funct));
      @(negedge clk);
      got = snap(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL jump cyc%0d got=%h want=%h", c, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [3:0] st [3];
    logic [19:0] got, want;
    st = '{4'd0, 4'd1, 4'd0};
    Op = 6'b111111; Funct = 6'd0; Zero = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mem_ready = (c < 2);
      sb.push_back(model(st[c], mem_ready, Zero, Op, Funct));
      @(negedge clk);
      got = snap(); want = sb.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL illegal cyc%0d got=%h want=%h", c, got, want);
      end
      n_tests++;
      if ({RegWrite, MemWrite} !== 2'b00) begin
        n_fail++; $display("FAIL illegal_no_write cyc%0d got=%b want=00", c, {RegWrite, MemWrite});
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lw_wait();
    test_sw_wait();
    test_reset_mid_memwrite();
    test_beq();
    test_rtype();
    test_addi_jump();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
